// File: rtl/input_loader_pkg.sv
// Shared definitions for the neuron-layer input loader.
//   INTEGER_WIDTH / FRACTION_WIDTH : fixed-point sample format
//   fixed_t                        : signed sample, bit 0 weighs 1.0
//   wr_state_e / rd_state_e        : loader write-side and read-side FSM states
package input_loader_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

  typedef enum logic {
    WrLoading,
    WrFull
  } wr_state_e;

  typedef enum logic {
    RdIdle,
    RdBusy
  } rd_state_e;

endpackage

// File: rtl/input_bank.sv
// One frame buffer: NumInputs fixed_t registers.
//   clk_i   : rising-edge clock
//   clear_i : synchronous clear of every entry (wins over write)
//   we_i    : write data_i into entry idx_i
//   idx_i   : entry index
//   data_i  : sample to store
//   data_o  : all entries, element 0 first
module input_bank
  import input_loader_pkg::*;
#(
  parameter int unsigned NumInputs = 16,
  parameter int unsigned IdxW      = $clog2(NumInputs)
) (
  input  logic            clk_i,
  input  logic            clear_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] idx_i,
  input  fixed_t          data_i,
  output fixed_t          data_o [NumInputs]
);

  fixed_t mem_q [NumInputs];
  fixed_t mem_d [NumInputs];

  always_comb begin
    mem_d = mem_q;
    if (clear_i) begin
      for (int i = 0; i < NumInputs; i++) begin
        mem_d[i] = '0;
      end
    end else if (we_i) begin
      mem_d[idx_i] = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o = mem_q;

endmodule

// File: rtl/input_loader.sv
// Double-buffered serial-to-parallel loader feeding a neuron layer.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   in_data       : stream sample (valid with in_valid)
//   in_valid      : in_data / in_last valid
//   in_last       : final sample of a frame
//   in_ready      : a sample is accepted this cycle if in_valid
//   inputs        : presented frame from the read bank, element 0 = first sample
//   inputs_ready  : one-cycle pulse after a new frame is presented
//   layer_done    : layer finished with the presented frame
//   busy          : a frame is presented and not yet released
//   frame_error   : sticky, a malformed frame was seen
module input_loader
  import input_loader_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 16
) (
  input  logic   clock,
  input  logic   reset,
  input  fixed_t in_data,
  input  logic   in_valid,
  input  logic   in_last,
  output logic   in_ready,
  output fixed_t inputs [NUM_INPUTS],
  output logic   inputs_ready,
  input  logic   layer_done,
  output logic   busy,
  output logic   frame_error
);

  localparam int unsigned CntW = $clog2(NUM_INPUTS);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_INPUTS - 1);

  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            inputs_ready_q, inputs_ready_d;
  logic            frame_error_q, frame_error_d;

  logic   accept;
  logic   at_last_idx;
  logic   frame_done;
  logic   malformed;
  logic   rd_free;
  logic   swap;
  fixed_t bank0_data [NUM_INPUTS];
  fixed_t bank1_data [NUM_INPUTS];

  assign in_ready    = (wr_state_q == WrLoading);
  assign accept      = in_valid && in_ready;
  assign at_last_idx = (count_q == LastIdx);
  assign frame_done  = accept && in_last && at_last_idx;
  // Early in_last or missing in_last both discard the frame.
  assign malformed   = accept && (in_last != at_last_idx);
  assign rd_free     = (rd_state_q == RdIdle) || layer_done;
  assign swap        = (frame_done || (wr_state_q == WrFull)) && rd_free;

  always_comb begin
    wr_state_d     = wr_state_q;
    rd_state_d     = rd_state_q;
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    frame_error_d  = frame_error_q;
    inputs_ready_d = swap;

    if (accept) begin
      count_d = (in_last || at_last_idx) ? '0 : count_q + CntW'(1);
    end
    if (malformed) begin
      frame_error_d = 1'b1;
    end

    if (swap) begin
      wr_ptr_d   = ~wr_ptr_q;
      wr_state_d = WrLoading;
      rd_state_d = RdBusy;
    end else begin
      if (frame_done) begin
        wr_state_d = WrFull;
      end
      // Release with no full frame waiting: go idle without a swap.
      if ((rd_state_q == RdBusy) && layer_done) begin
        rd_state_d = RdIdle;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q     <= WrLoading;
      rd_state_q     <= RdIdle;
      count_q        <= '0;
      wr_ptr_q       <= 1'b0;
      inputs_ready_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      wr_state_q     <= wr_state_d;
      rd_state_q     <= rd_state_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      inputs_ready_q <= inputs_ready_d;
      frame_error_q  <= frame_error_d;
    end
  end

  // Writes go only to the filling bank, so the presented bank stays stable.
  input_bank #(
    .NumInputs (NUM_INPUTS),
    .IdxW      (CntW)
  ) u_bank0 (
    .clk_i   (clock),
    .clear_i (reset),
    .we_i    (accept && !wr_ptr_q),
    .idx_i   (count_q),
    .data_i  (in_data),
    .data_o  (bank0_data)
  );

  input_bank #(
    .NumInputs (NUM_INPUTS),
    .IdxW      (CntW)
  ) u_bank1 (
    .clk_i   (clock),
    .clear_i (reset),
    .we_i    (accept && wr_ptr_q),
    .idx_i   (count_q),
    .data_i  (in_data),
    .data_o  (bank1_data)
  );

  // Read bank is the one not being filled.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      inputs[i] = wr_ptr_q ? bank0_data[i] : bank1_data[i];
    end
  end

  assign inputs_ready = inputs_ready_q;
  assign busy         = (rd_state_q == RdBusy);
  assign frame_error  = frame_error_q;

endmodule
